// File: rtl/led_matrix_scan_if.sv
// Frame hand-off bus between the note renderer and the LED matrix scanner.
// The renderer drives a full 8x8 RGB bitmap; the scanner accepts it when ready.
interface led_matrix_scan_if;
  logic [191:0] bitmap;
  logic         frame_valid;
  logic         frame_ready;

  modport master (output bitmap, output frame_valid, input frame_ready);
  modport slave  (input bitmap, input frame_valid, output frame_ready);
endinterface

// File: rtl/led_matrix_scan.sv
// Scans an 8x8 RGB matrix one row at a time: shift eight columns, latch them, then light the row.
// A pending buffer holds the next frame and is swapped in only at a frame boundary.
module led_matrix_scan #(
  parameter int CLK_DIV = 2,
  parameter int DWELL   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  led_matrix_scan_if.slave         frm,
  output logic [7:0]               row_n,
  output logic                     ser_r,
  output logic                     ser_g,
  output logic                     ser_b,
  output logic                     sclk,
  output logic                     latch,
  output logic                     oe_n,
  output logic                     frame_done
);

  localparam int TMR_MAX = (CLK_DIV > DWELL) ? CLK_DIV : DWELL;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {SHIFT, LATCH, DISPLAY} state_t;

  state_t             state, state_nxt;
  logic [2:0]         row, row_nxt;
  logic [2:0]         bit_idx, bit_idx_nxt;
  logic               hi, hi_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic               end_of_frame;

  logic [191:0]       active;
  logic [191:0]       pending;
  logic               pending_full;

  logic [5:0]         pix;
  logic [7:0]         base;
  logic [2:0]         rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SHIFT;
      row     <= '0;
      bit_idx <= '0;
      hi      <= 1'b0;
      tmr     <= '0;
    end else begin
      state   <= state_nxt;
      row     <= row_nxt;
      bit_idx <= bit_idx_nxt;
      hi      <= hi_nxt;
      tmr     <= tmr_nxt;
    end
  end

  // Column sent first is 7, so bit_idx counts up while the column counts down.
  always_comb begin
    state_nxt    = state;
    row_nxt      = row;
    bit_idx_nxt  = bit_idx;
    hi_nxt       = hi;
    tmr_nxt      = tmr + TMR_W'(1);
    end_of_frame = 1'b0;
    case (state)
      SHIFT: begin
        if (tmr == TMR_W'(CLK_DIV - 1)) begin
          tmr_nxt = '0;
          if (!hi) begin
            hi_nxt = 1'b1;
          end else begin
            hi_nxt = 1'b0;
            if (bit_idx == 3'd7) begin
              state_nxt   = LATCH;
              bit_idx_nxt = '0;
            end else begin
              bit_idx_nxt = bit_idx + 3'd1;
            end
          end
        end
      end
      LATCH: begin
        tmr_nxt   = '0;
        state_nxt = DISPLAY;
      end
      DISPLAY: begin
        if (tmr == TMR_W'(DWELL - 1)) begin
          tmr_nxt      = '0;
          state_nxt    = SHIFT;
          row_nxt      = row + 3'd1;
          end_of_frame = (row == 3'd7);
        end
      end
      default: begin
        state_nxt = SHIFT;
        tmr_nxt   = '0;
      end
    endcase
  end

  // Swap and accept are mutually exclusive: ready is low whenever a swap is possible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (end_of_frame && pending_full) begin
      active       <= pending;
      pending_full <= 1'b0;
    end else if (frm.frame_valid && !pending_full) begin
      pending      <= frm.bitmap;
      pending_full <= 1'b1;
    end
  end

  assign frm.frame_ready = ~pending_full;

  assign pix  = {row, 3'd7 - bit_idx};
  assign base = 8'(pix) * 8'd3;
  assign rgb  = active[base +: 3];

  always_comb begin
    row_n      = 8'hFF;
    oe_n       = 1'b1;
    latch      = 1'b0;
    sclk       = 1'b0;
    ser_r      = 1'b0;
    ser_g      = 1'b0;
    ser_b      = 1'b0;
    frame_done = end_of_frame;
    case (state)
      SHIFT: begin
        sclk  = hi;
        ser_r = rgb[0];
        ser_g = rgb[1];
        ser_b = rgb[2];
      end
      LATCH:   latch = 1'b1;
      DISPLAY: begin
        oe_n  = 1'b0;
        row_n = ~(8'd1 << row);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: two instances (default timing and CLK_DIV=1/DWELL=1) share the
// same randomized frame stimulus; a per-cycle reference model feeds a scoreboard queue.
module tb_led_matrix_scan;

  typedef struct packed {
    logic [7:0] row_n;
    logic       oe_n;
    logic       latch;
    logic       sclk;
    logic       fd;
    logic       rdy;
    logic [2:0] ser;   // {b,g,r}
  } obs_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [191:0] bitmap = '0;
  logic         frame_valid = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  localparam obs_t RST_OBS = '{row_n: 8'hFF, oe_n: 1'b1, latch: 1'b0, sclk: 1'b0,
                               fd: 1'b0, rdy: 1'b1, ser: 3'b000};

  always #5 clk = ~clk;

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int CD = (g == 0) ? 2 : 1;
    localparam int DW = (g == 0) ? 16 : 1;
    localparam int RP = 16 * CD + 1 + DW;
    localparam int FP = 8 * RP;

    led_matrix_scan_if ifc ();
    logic [7:0] row_n;
    logic       ser_r, ser_g, ser_b, sclk, latch, oe_n, fd;

    assign ifc.bitmap      = bitmap;
    assign ifc.frame_valid = frame_valid;

    led_matrix_scan #(.CLK_DIV(CD), .DWELL(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .frm        (ifc),
      .row_n      (row_n),
      .ser_r      (ser_r),
      .ser_g      (ser_g),
      .ser_b      (ser_b),
      .sclk       (sclk),
      .latch      (latch),
      .oe_n       (oe_n),
      .frame_done (fd)
    );

    obs_t         exp_q[$];
    logic         shf_q[$];
    logic [191:0] m_act, m_pend;
    logic         m_pf;
    int           m_cyc;

    // Reference model: position in the frame decides the panel waveform.
    always @(negedge clk) begin
      obs_t e;
      logic sh;
      int   row, p, col;
      if (rst) begin
        e      = RST_OBS;
        sh     = 1'b1;
        m_act  = '0;
        m_pend = '0;
        m_pf   = 1'b0;
        m_cyc  = 0;
      end else begin
        row = m_cyc / RP;
        p   = m_cyc % RP;
        e   = '{row_n: 8'hFF, oe_n: 1'b1, latch: 1'b0, sclk: 1'b0,
                fd: 1'b0, rdy: !m_pf, ser: 3'b000};
        sh  = 1'b0;
        if (p < 16 * CD) begin
          sh     = 1'b1;
          col    = 7 - p / (2 * CD);
          e.sclk = (p % (2 * CD)) >= CD;
          e.ser  = m_act[(row * 8 + col) * 3 +: 3];
        end else if (p == 16 * CD) begin
          e.latch = 1'b1;
        end else begin
          e.oe_n  = 1'b0;
          e.row_n = ~(8'd1 << row);
          e.fd    = (row == 7) && (p == RP - 1);
        end
        if (e.fd && m_pf) begin
          m_act = m_pend;
          m_pf  = 1'b0;
        end else if (frame_valid && !m_pf) begin
          m_pend = bitmap;
          m_pf   = 1'b1;
        end
        m_cyc = (m_cyc + 1) % FP;
      end
      exp_q.push_back(e);
      shf_q.push_back(sh);
    end

    always @(negedge clk) begin
      obs_t e, a;
      logic sh;
      #2;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_empty inst=%0d actual=0 required=1 at %0t", g, $time);
      end else begin
        e  = exp_q.pop_front();
        sh = shf_q.pop_front();
        a  = '{row_n: row_n, oe_n: oe_n, latch: latch, sclk: sclk, fd: fd,
               rdy: ifc.frame_ready, ser: {ser_b, ser_g, ser_r}};
        if (!sh) begin
          a.ser = 3'b000;
          e.ser = 3'b000;
        end
        chk((g == 0) ? "scan_div2_dw16" : "scan_div1_dw1", a, e);
      end
    end
  end

  function automatic logic [191:0] rand_bm();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_fd0();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (u[0].fd) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL frame_done_timeout actual=0 required=1 at %0t", $time);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [191:0] bm);
    bitmap      = bm;
    frame_valid = 1'b1;
    cycles(1);
    frame_valid = 1'b0;
    bitmap      = rand_bm();
  endtask

  initial begin
    cycles(3);
    rst = 1'b0;

    // Idle scan with an all-zero frame.
    cycles(2 * 392 + 20);

    // Single red pixel at row 0, column 0.
    send(192'd1);
    cycles(3 * 392);

    // Frame A, then B offered continuously until it is taken at the swap.
    send(rand_bm());
    bitmap      = rand_bm();
    frame_valid = 1'b1;
    cycles(2 * 392 + 60);
    frame_valid = 1'b0;
    cycles(392);

    // New frame arriving in the middle of row 3.
    wait_fd0();
    cycles(3 * 49 + 20);
    send(rand_bm());
    cycles(2 * 392);

    // Random offers, sometimes with sparse bitmaps.
    for (int i = 0; i < 1500; i++) begin
      bitmap      = ($urandom_range(0, 1) == 0) ? rand_bm() : (rand_bm() & rand_bm() & rand_bm());
      frame_valid = ($urandom_range(0, 40) == 0);
      cycles(1);
    end
    frame_valid = 1'b0;
    cycles(2 * 392);

    // Reset while row 5 of the default instance is lit.
    wait_fd0();
    cycles(5 * 49 + 33 + 6);
    chk("row5_lit_before_rst", '{row_n: u[0].row_n, oe_n: u[0].oe_n, latch: 1'b0, sclk: 1'b0,
                                  fd: 1'b0, rdy: 1'b1, ser: 3'b000},
        '{row_n: 8'hDF, oe_n: 1'b0, latch: 1'b0, sclk: 1'b0, fd: 1'b0, rdy: 1'b1, ser: 3'b000});
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      obs_t a;
      a = (k == 0)
        ? '{row_n: u[0].row_n, oe_n: u[0].oe_n, latch: u[0].latch, sclk: u[0].sclk, fd: u[0].fd,
            rdy: u[0].ifc.frame_ready, ser: {u[0].ser_b, u[0].ser_g, u[0].ser_r}}
        : '{row_n: u[1].row_n, oe_n: u[1].oe_n, latch: u[1].latch, sclk: u[1].sclk, fd: u[1].fd,
            rdy: u[1].ifc.frame_ready, ser: {u[1].ser_b, u[1].ser_g, u[1].ser_r}};
      chk((k == 0) ? "async_rst_div2" : "async_rst_div1", a, RST_OBS);
    end
    cycles(2);
    rst = 1'b0;
    cycles(392 + 60);
    send(rand_bm());
    cycles(2 * 392);

    cycles(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
